// File: rtl/apb_spi_pkg.sv
// Shared types for the APB-to-SPI register bank.
// Holds the bus FSM state encoding and the wait counter width.
package apb_spi_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

endpackage

// File: rtl/apb_spi_addr_dec.sv
// Address decoder for the APB-to-SPI register bank.
// Flags out-of-range or read-only targets and makes one-hot selects.
module apb_spi_addr_dec #(
  parameter int AWIDTH  = 8,
  parameter int REGN    = 6,
  parameter int REGTX_N = 3
) (
  input  logic [AWIDTH-1:0]       addr,
  input  logic                    write,
  output logic [REGTX_N-1:0]      tx_sel,
  output logic [REGN-REGTX_N-1:0] rx_sel,
  output logic                    addr_err
);

  localparam int RXN = REGN - REGTX_N;

  logic [31:0] idx;

  // Range check first, then one-hot selects gated by a legal access.
  always_comb begin
    idx      = 32'(addr);
    tx_sel   = '0;
    rx_sel   = '0;
    addr_err = (idx >= 32'(REGN)) ||
               (write && (idx >= 32'(REGTX_N)));
    for (int i = 0; i < REGTX_N; i++) begin
      if (!addr_err && idx == 32'(i))
        tx_sel[i] = 1'b1;
    end
    for (int j = 0; j < RXN; j++) begin
      if (!addr_err && !write &&
          idx == 32'(REGTX_N + j))
        rx_sel[j] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_spi_regbank.sv
// APB slave register bank between a host bus and an SPI core.
// TX regs are host-written, RX regs are core-written and host-read.
module apb_spi_regbank
  import apb_spi_pkg::*;
#(
  parameter int AWIDTH      = 8,
  parameter int DWIDTH      = 8,
  parameter int REGN        = 6,
  parameter int REGTX_N     = 3,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [AWIDTH-1:0]         PADDR,
  input  logic [DWIDTH-1:0]         PWDATA,
  output logic [DWIDTH-1:0]         PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [REGTX_N*DWIDTH-1:0] tx_data,
  output logic [REGTX_N-1:0]        tx_valid,
  input  logic [REGTX_N-1:0]        tx_ack,
  input  logic [DWIDTH-1:0]         rx_data,
  input  logic [REGN-REGTX_N-1:0]   rx_wr,
  output logic [REGN-REGTX_N-1:0]   rx_full,
  output logic [REGN-REGTX_N-1:0]   rx_ovr
);

  localparam int RXN = REGN - REGTX_N;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DWIDTH-1:0]   rx_q [RXN];
  logic [REGTX_N-1:0]  tx_sel;
  logic [RXN-1:0]      rx_sel;
  logic                addr_err;
  logic                fire;
  logic                wr_en;
  logic                rd_en;
  logic [DWIDTH-1:0]   rd_val;

  apb_spi_addr_dec #(
    .AWIDTH  (AWIDTH),
    .REGN    (REGN),
    .REGTX_N (REGTX_N)
  ) u_dec (
    .addr     (PADDR),
    .write    (PWRITE),
    .tx_sel   (tx_sel),
    .rx_sel   (rx_sel),
    .addr_err (addr_err)
  );

  // fire marks the edge that raises PREADY; side effects commit here
  // so they are visible during the completion cycle itself.
  always_comb begin
    fire = 1'b0;
    if (PSEL) begin
      if (state == SETUP && WAIT_CYCLES == 0)
        fire = 1'b1;
      if (state == ACCESS && !PREADY &&
          cnt == CNT_W'(1))
        fire = 1'b1;
    end
    wr_en = fire && PWRITE && !addr_err;
    rd_en = fire && !PWRITE && !addr_err;
  end

  // Read mux over both banks; selects are already gated legal.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < REGTX_N; i++) begin
      if (tx_sel[i] && !PWRITE)
        rd_val = tx_data[i*DWIDTH +: DWIDTH];
    end
    for (int j = 0; j < RXN; j++) begin
      if (rx_sel[j])
        rd_val = rx_q[j];
    end
  end

  // Bus FSM with wait counter and registered response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= fire;
      PSLVERR <= fire && addr_err;
      PRDATA  <= rd_en ? rd_val : '0;
      unique case (state)
        IDLE: begin
          if (PSEL && !PENABLE)
            state <= SETUP;
        end
        SETUP: begin
          if (!PSEL) begin
            state <= IDLE;
          end else begin
            state <= ACCESS;
            cnt   <= CNT_W'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (PREADY) begin
            state <= (PSEL && !PENABLE) ?
                     SETUP : IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // TX bank: a host write beats a same-cycle ack from the core.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_data  <= '0;
      tx_valid <= '0;
    end else begin
      for (int i = 0; i < REGTX_N; i++) begin
        if (wr_en && tx_sel[i]) begin
          tx_data[i*DWIDTH +: DWIDTH] <= PWDATA;
          tx_valid[i] <= 1'b1;
        end else if (tx_ack[i]) begin
          tx_valid[i] <= 1'b0;
        end
      end
    end
  end

  // RX bank: a core load beats a same-cycle host read-clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int j = 0; j < RXN; j++)
        rx_q[j] <= '0;
      rx_full <= '0;
      rx_ovr  <= '0;
    end else begin
      for (int j = 0; j < RXN; j++) begin
        if (rx_wr[j]) begin
          rx_q[j]    <= rx_data;
          rx_full[j] <= 1'b1;
          if (rx_full[j] && !(rd_en && rx_sel[j]))
            rx_ovr[j] <= 1'b1;
        end else if (rd_en && rx_sel[j]) begin
          rx_full[j] <= 1'b0;
          rx_ovr[j]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_spi_regbank.sv
// Directed bench for apb_spi_regbank.
// Three instances cover WAIT_CYCLES of 0, 3 and 2.
module tb_apb_spi_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel0, psel3, psel2;
  logic        pen, pwr;
  logic [7:0]  paddr, pwdata;
  logic [2:0]  tx_ack;
  logic [7:0]  rx_data;
  logic [2:0]  rx_wr;

  logic [7:0]  prdata0, prdata3, prdata2;
  logic        pready0, pready3, pready2;
  logic        perr0, perr3, perr2;
  logic [23:0] txd0, txd3, txd2;
  logic [2:0]  txv0, txv3, txv2;
  logic [2:0]  rxf0, rxf3, rxf2;
  logic [2:0]  rxo0, rxo3, rxo2;

  int npass = 0;
  int ntot  = 0;
  int n;
  logic [7:0] rd;
  logic       er;
  logic       seen;

  always #5 clk = ~clk;

  apb_spi_regbank #(.WAIT_CYCLES(0)) d0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0),
    .PENABLE(pen), .PWRITE(pwr), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(perr0),
    .tx_data(txd0), .tx_valid(txv0),
    .tx_ack(tx_ack), .rx_data(rx_data),
    .rx_wr(rx_wr), .rx_full(rxf0), .rx_ovr(rxo0)
  );

  apb_spi_regbank #(.WAIT_CYCLES(3)) d3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel3),
    .PENABLE(pen), .PWRITE(pwr), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata3),
    .PREADY(pready3), .PSLVERR(perr3),
    .tx_data(txd3), .tx_valid(txv3),
    .tx_ack(tx_ack), .rx_data(rx_data),
    .rx_wr(rx_wr), .rx_full(rxf3), .rx_ovr(rxo3)
  );

  apb_spi_regbank #(.WAIT_CYCLES(2)) d2 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel2),
    .PENABLE(pen), .PWRITE(pwr), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata2),
    .PREADY(pready2), .PSLVERR(perr2),
    .tx_data(txd2), .tx_valid(txv2),
    .tx_ack(tx_ack), .rx_data(rx_data),
    .rx_wr(rx_wr), .rx_full(rxf2), .rx_ovr(rxo2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic sel(input int w, input logic v);
    psel0 = (w == 0) ? v : 1'b0;
    psel3 = (w == 3) ? v : 1'b0;
    psel2 = (w == 2) ? v : 1'b0;
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? pready0 :
           (w == 3) ? pready3 : pready2;
  endfunction

  function automatic logic [7:0] rdat(input int w);
    return (w == 0) ? prdata0 :
           (w == 3) ? prdata3 : prdata2;
  endfunction

  function automatic logic rerr(input int w);
    return (w == 0) ? perr0 :
           (w == 3) ? perr3 : perr2;
  endfunction

  // Returns at the negedge of the completion cycle, bus held.
  task automatic apb(input int w, input logic wr,
                     input logic [7:0] a,
                     input logic [7:0] d,
                     output int cyc,
                     output logic [7:0] r,
                     output logic e);
    @(negedge clk);
    sel(w, 1'b1);
    pen = 1'b0; pwr = wr; paddr = a; pwdata = d;
    @(negedge clk);
    pen = 1'b1;
    cyc = 0; r = 8'h00; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy(w)) begin
        cyc = k; r = rdat(w); e = rerr(w);
        break;
      end
    end
  endtask

  task automatic idle();
    sel(0, 1'b0);
    pen = 1'b0; pwr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    sel(0, 1'b0);
    pen = 0; pwr = 0; paddr = 0; pwdata = 0;
    tx_ack = 0; rx_data = 0; rx_wr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_pready", pready0, 0);
    chk("rst_prdata", prdata0, 0);
    chk("rst_pslverr", perr0, 0);
    chk("rst_txd", txd0, 0);
    chk("rst_txv", txv0, 0);
    chk("rst_rxf", rxf0, 0);
    chk("rst_rxo", rxo0, 0);

    apb(0, 1, 8'd1, 8'hA5, n, rd, er);
    chk("w1_cyc", n, 1);
    chk("w1_err", er, 0);
    chk("w1_txd1", txd0[15:8], 8'hA5);
    chk("w1_txv", txv0, 3'b010);
    idle();
    chk("w1_pready_low", pready0, 0);
    chk("w1_prdata_low", prdata0, 0);

    apb(0, 0, 8'd1, 8'h00, n, rd, er);
    chk("r1_data", rd, 8'hA5);
    chk("r1_err", er, 0);
    chk("r1_txv", txv0, 3'b010);
    idle();

    apb(3, 1, 8'd0, 8'h5C, n, rd, er);
    chk("w3_cyc", n, 4);
    idle();
    apb(3, 0, 8'd0, 8'h00, n, rd, er);
    chk("r3_cyc", n, 4);
    chk("r3_data", rd, 8'h5C);
    chk("r3_err", er, 0);
    idle();

    apb(0, 1, 8'd6, 8'hEE, n, rd, er);
    chk("w6_err", er, 1);
    chk("w6_rd", rd, 0);
    idle();
    apb(0, 1, 8'd4, 8'hDD, n, rd, er);
    chk("w4_err", er, 1);
    chk("w4_rd", rd, 0);
    idle();
    chk("err_txd", txd0, 24'h00A500);
    chk("err_txv", txv0, 3'b010);
    chk("err_rxf", rxf0, 0);
    apb(0, 0, 8'd7, 8'h00, n, rd, er);
    chk("r7_err", er, 1);
    idle();
    apb(0, 0, 8'd4, 8'h00, n, rd, er);
    chk("r4_empty", rd, 0);
    chk("r4_err", er, 0);
    idle();

    @(negedge clk);
    sel(0, 1'b1); pen = 0; pwr = 1;
    paddr = 8'd0; pwdata = 8'h66;
    @(negedge clk);
    sel(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("abort_pready", pready0, 0);
    chk("abort_txv", txv0, 3'b010);
    chk("abort_txd0", txd0[7:0], 0);

    rx_data = 8'h11; rx_wr = 3'b001;
    @(negedge clk);
    rx_data = 8'h22;
    @(negedge clk);
    rx_wr = 3'b000;
    chk("ovr_full", rxf0, 3'b001);
    chk("ovr_ovr", rxo0, 3'b001);
    apb(0, 0, 8'd3, 8'h00, n, rd, er);
    chk("r3x_data", rd, 8'h22);
    chk("r3x_full", rxf0, 3'b000);
    chk("r3x_ovr", rxo0, 3'b000);
    idle();

    rx_data = 8'h3C; rx_wr = 3'b110;
    @(negedge clk);
    rx_wr = 3'b000;
    chk("multi_full", rxf0, 3'b110);
    chk("multi_ovr", rxo0, 3'b000);
    apb(0, 0, 8'd4, 8'h00, n, rd, er);
    chk("multi_r4", rd, 8'h3C);
    idle();
    apb(0, 0, 8'd5, 8'h00, n, rd, er);
    chk("multi_r5", rd, 8'h3C);
    idle();

    rx_data = 8'h44; rx_wr = 3'b001;
    @(negedge clk);
    rx_wr = 3'b000;
    sel(0, 1'b1); pen = 0; pwr = 0; paddr = 8'd3;
    @(negedge clk);
    pen = 1; rx_data = 8'h55; rx_wr = 3'b001;
    @(negedge clk);
    rx_wr = 3'b000;
    chk("sim_pready", pready0, 1);
    chk("sim_old", prdata0, 8'h44);
    chk("sim_full", rxf0[0], 1);
    chk("sim_ovr", rxo0[0], 0);
    idle();
    apb(0, 0, 8'd3, 8'h00, n, rd, er);
    chk("sim_new", rd, 8'h55);
    idle();
    chk("sim_cleared", rxf0[0], 0);

    apb(0, 1, 8'd2, 8'h33, n, rd, er);
    idle();
    chk("ack_pre", txv0[2], 1);
    tx_ack = 3'b100;
    apb(0, 1, 8'd2, 8'h77, n, rd, er);
    tx_ack = 3'b000;
    chk("ack_win_v", txv0[2], 1);
    chk("ack_win_d", txd0[23:16], 8'h77);
    idle();
    chk("ack_win_hold", txv0[2], 1);
    tx_ack = 3'b110;
    @(negedge clk);
    tx_ack = 3'b000;
    chk("ack_clr", txv0, 3'b000);
    chk("ack_data", txd0, 24'h77A500);

    apb(2, 1, 8'd0, 8'h12, n, rd, er);
    chk("w2_cyc", n, 3);
    idle();
    chk("w2_txd", txd2[7:0], 8'h12);
    @(negedge clk);
    sel(2, 1'b1); pen = 0; pwr = 1;
    paddr = 8'd0; pwdata = 8'h99;
    @(negedge clk);
    pen = 1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_pready", pready2, 0);
    chk("mrst_prdata", prdata2, 0);
    chk("mrst_pslverr", perr2, 0);
    chk("mrst_txd", txd2, 0);
    chk("mrst_txv", txv2, 0);
    chk("mrst_rx", {rxf2, rxo2}, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready2) seen = 1'b1;
    end
    chk("mrst_no_ready", seen, 0);
    idle();
    apb(2, 0, 8'd0, 8'h00, n, rd, er);
    chk("mrst_r_cyc", n, 3);
    chk("mrst_r_data", rd, 8'h00);
    idle();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
